// File: rtl/float_mul_scheduler.sv
// Round-robin scheduler sharing one combinational fp multiplier across NUM_REQ requesters.
// Optional stall/issue statistics outputs: define FLOAT_MUL_SCHED_STATS_EN.

package fp_pkg;
  typedef struct packed {
    logic       sign;
    logic [4:0] exponent;
    logic [9:0] mantissa;
  } fp16_t;

  localparam int FP16_EXP_W = 5;
endpackage

module float_multi #(
  parameter type fp_t  = fp_pkg::fp16_t,
  parameter int  EXP_W = fp_pkg::FP16_EXP_W
) (
  input  fp_t a_i,
  input  fp_t b_i,
  output fp_t p_o
);
  localparam int W    = $bits(fp_t);
  localparam int MW   = W - 1 - EXP_W;
  localparam int PW   = 2 * MW + 2;
  localparam int EXW  = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  logic [W-1:0]          a_s, b_s, p_s;
  logic [EXP_W-1:0]      a_exp_s, b_exp_s;
  logic [MW-1:0]         a_man_s, b_man_s, man_s;
  logic [PW-1:0]         prod_s;
  logic [MW:0]           man_rnd_s;
  logic                  sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic                  guard_s, sticky_s, round_s;
  logic signed [EXW-1:0] exp_s;

  assign a_s = a_i;
  assign b_s = b_i;
  assign p_o = p_s;

  // Subnormal inputs and results flush to zero; rounding is nearest-even.
  always_comb begin
    sign_s   = a_s[W-1] ^ b_s[W-1];
    a_exp_s  = a_s[W-2 -: EXP_W];
    b_exp_s  = b_s[W-2 -: EXP_W];
    a_man_s  = a_s[MW-1:0];
    b_man_s  = b_s[MW-1:0];
    a_zero_s = (a_exp_s == '0);
    b_zero_s = (b_exp_s == '0);
    a_inf_s  = (a_exp_s == '1) && (a_man_s == '0);
    b_inf_s  = (b_exp_s == '1) && (b_man_s == '0);
    a_nan_s  = (a_exp_s == '1) && (a_man_s != '0);
    b_nan_s  = (b_exp_s == '1) && (b_man_s != '0);
    prod_s   = PW'({1'b1, a_man_s}) * PW'({1'b1, b_man_s});
    if (prod_s[PW-1]) begin
      man_s    = prod_s[PW-2 -: MW];
      guard_s  = prod_s[MW];
      sticky_s = |prod_s[MW-1:0];
    end else begin
      man_s    = prod_s[PW-3 -: MW];
      guard_s  = prod_s[MW-1];
      sticky_s = |prod_s[MW-2:0];
    end
    round_s   = guard_s & (sticky_s | man_s[0]);
    man_rnd_s = {1'b0, man_s} + {{MW{1'b0}}, round_s};
    exp_s     = $signed(EXW'(a_exp_s)) + $signed(EXW'(b_exp_s)) - $signed(EXW'(BIAS))
              + $signed(EXW'(prod_s[PW-1])) + $signed(EXW'(man_rnd_s[MW]));
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      p_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    end else if (a_inf_s || b_inf_s) begin
      p_s = {sign_s, {EXP_W{1'b1}}, {MW{1'b0}}};
    end else if (a_zero_s || b_zero_s) begin
      p_s = {sign_s, {(W-1){1'b0}}};
    end else if (exp_s >= $signed(EXW'((1 << EXP_W) - 1))) begin
      p_s = {sign_s, {EXP_W{1'b1}}, {MW{1'b0}}};
    end else if (exp_s < $signed(EXW'(1))) begin
      p_s = {sign_s, {(W-1){1'b0}}};
    end else begin
      p_s = {sign_s, exp_s[EXP_W-1:0], man_rnd_s[MW-1:0]};
    end
  end
endmodule

module float_mul_scheduler #(
  parameter type fp_t    = fp_pkg::fp16_t,
  parameter int  NUM_REQ = 4,
  parameter int  LATENCY = 2,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int FPW     = $bits(fp_t)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][FPW-1:0]   req_opa_i,
  input  logic [NUM_REQ-1:0][FPW-1:0]   req_opb_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [IDW-1:0]                rsp_id_o,
  output logic [FPW-1:0]                rsp_result_o,
  input  logic                          drain_i,
  output logic                          idle_o
`ifdef FLOAT_MUL_SCHED_STATS_EN
  ,
  output logic [31:0]                   stat_issue_cnt_o,
  output logic [31:0]                   stat_stall_cnt_o
`endif
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q;
  logic [IDW-1:0]       rr_q;
  logic [LATENCY-1:0]   valid_q;
  logic [IDW-1:0]       id_q  [LATENCY];
  fp_t                  opa_q [LATENCY];
  fp_t                  opb_q [LATENCY];
  fp_t                  mul_s;

  logic                 stall_s, any_valid_s, pipe_empty_s, accept_s, gnt_found_s;
  logic [IDW-1:0]       gnt_idx_s;
  logic [IDW:0]         cand_s;

  assign rsp_valid_o  = valid_q[LATENCY-1];
  assign rsp_id_o     = id_q[LATENCY-1];
  assign rsp_result_o = mul_s;
  assign pipe_empty_s = (valid_q == '0);
  assign idle_o       = (state_q == IDLE) && pipe_empty_s;

  // Round-robin search from rr_q upward with wrap; drain and stall block any grant.
  always_comb begin
    any_valid_s = |req_valid_i;
    stall_s     = rsp_valid_o & ~rsp_ready_i;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = (IDW+1)'(rr_q) + (IDW+1)'(k);
      if (cand_s >= (IDW+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IDW+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_found_s && req_valid_i[cand_s[IDW-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s[IDW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    accept_s    = (state_q == RUN) && !drain_i && !stall_s && gnt_found_s;
    req_ready_o = '0;
    if (accept_s) begin
      req_ready_o[gnt_idx_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Global-stall pipeline; payload only moves with a valid so outputs hold between responses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        id_q[s]  <= '0;
        opa_q[s] <= '0;
        opb_q[s] <= '0;
      end
    end else if (!stall_s) begin
      valid_q[0] <= accept_s;
      if (accept_s) begin
        id_q[0]  <= gnt_idx_s;
        opa_q[0] <= req_opa_i[gnt_idx_s];
        opb_q[0] <= req_opb_i[gnt_idx_s];
      end
      for (int s = 1; s < LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) begin
          id_q[s]  <= id_q[s-1];
          opa_q[s] <= opa_q[s-1];
          opb_q[s] <= opb_q[s-1];
        end
      end
    end
  end

  // Control FSM and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
    end else begin
      if (accept_s) begin
        rr_q <= (gnt_idx_s == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
      end
      case (state_q)
        IDLE: begin
          if (any_valid_s && !drain_i) state_q <= RUN;
        end
        RUN: begin
          if (drain_i) state_q <= DRAIN;
          else if (!any_valid_s && pipe_empty_s) state_q <= IDLE;
        end
        DRAIN: begin
          if (!drain_i && pipe_empty_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  float_multi #(.fp_t(fp_t)) u_mul (
    .a_i (opa_q[LATENCY-1]),
    .b_i (opb_q[LATENCY-1]),
    .p_o (mul_s)
  );

`ifdef FLOAT_MUL_SCHED_STATS_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  // Saturating activity counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issue_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (accept_s && (issue_cnt_q != 32'hFFFF_FFFF)) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_issue_cnt_o = issue_cnt_q;
  assign stat_stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_float_mul_scheduler.sv
// Directed bench for float_mul_scheduler (4 req / latency 2) plus scoreboarded
// random traffic on 3-requester instances with latency 1 and 8.
module tb_float_mul_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]       rv, rrdy;
  logic [3:0][15:0] opa, opb;
  logic             rsp_v, rsp_r, drain, idle;
  logic [1:0]       rsp_id;
  logic [15:0]      rsp_res;

  logic [2:0]       xv [2];
  logic [2:0]       xrdy [2];
  logic [2:0][15:0] xa [2];
  logic [2:0][15:0] xb [2];
  logic             xrv [2];
  logic             xrr [2];
  logic [1:0]       xid [2];
  logic [15:0]      xres [2];
  logic             xidle [2];
`ifdef FLOAT_MUL_SCHED_STATS_EN
  logic [31:0] s0i, s0s, s1i, s1s, s2i, s2s;
`endif

  float_mul_scheduler #(.NUM_REQ(4), .LATENCY(2)) d0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv), .req_ready_o(rrdy),
    .req_opa_i(opa), .req_opb_i(opb), .rsp_valid_o(rsp_v), .rsp_ready_i(rsp_r),
    .rsp_id_o(rsp_id), .rsp_result_o(rsp_res), .drain_i(drain), .idle_o(idle)
`ifdef FLOAT_MUL_SCHED_STATS_EN
    , .stat_issue_cnt_o(s0i), .stat_stall_cnt_o(s0s)
`endif
  );

  float_mul_scheduler #(.NUM_REQ(3), .LATENCY(1)) d1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(xv[0]), .req_ready_o(xrdy[0]),
    .req_opa_i(xa[0]), .req_opb_i(xb[0]), .rsp_valid_o(xrv[0]), .rsp_ready_i(xrr[0]),
    .rsp_id_o(xid[0]), .rsp_result_o(xres[0]), .drain_i(1'b0), .idle_o(xidle[0])
`ifdef FLOAT_MUL_SCHED_STATS_EN
    , .stat_issue_cnt_o(s1i), .stat_stall_cnt_o(s1s)
`endif
  );

  float_mul_scheduler #(.NUM_REQ(3), .LATENCY(8)) d2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(xv[1]), .req_ready_o(xrdy[1]),
    .req_opa_i(xa[1]), .req_opb_i(xb[1]), .rsp_valid_o(xrv[1]), .rsp_ready_i(xrr[1]),
    .rsp_id_o(xid[1]), .rsp_result_o(xres[1]), .drain_i(1'b0), .idle_o(xidle[1])
`ifdef FLOAT_MUL_SCHED_STATS_EN
    , .stat_issue_cnt_o(s2i), .stat_stall_cnt_o(s2s)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed fp16 products: 1*2, 2*2, 1.5*-2, 0.5*0.5.
  logic [15:0] ep [4] = '{16'h4000, 16'h4400, 16'hC200, 16'h3400};
  // Random table: rounding, 2*3, 1.5*-2, 0.5*0.5, zero, -1*-1, 4*0.75, overflow.
  logic [15:0] tab_a [8] = '{16'h3C01, 16'h4000, 16'h3E00, 16'h3800, 16'h0000, 16'hBC00, 16'h4400, 16'h7800};
  logic [15:0] tab_b [8] = '{16'h3C01, 16'h4200, 16'hC000, 16'h3800, 16'h4500, 16'hBC00, 16'h3A00, 16'h7800};
  logic [15:0] tab_p [8] = '{16'h3C02, 16'h4600, 16'hC200, 16'h3400, 16'h0000, 16'h3C00, 16'h4200, 16'h7C00};

  logic [17:0] sbq [2][$];
  logic [15:0] xexp [2][3];
  logic [2:0]  xacc [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [17:0] ent;
    int k;
    rst_n = 1'b0; rv = 4'h0; rsp_r = 1'b1; drain = 1'b0;
    for (int r = 0; r < 4; r++) begin
      opa[r] = 16'h0000; opb[r] = 16'h0000;
    end
    opa[0] = 16'h3C00; opb[0] = 16'h4000;
    opa[1] = 16'h4000; opb[1] = 16'h4000;
    opa[2] = 16'h3E00; opb[2] = 16'hC000;
    opa[3] = 16'h3800; opb[3] = 16'h3800;
    for (int u = 0; u < 2; u++) begin
      xv[u] = 3'b000; xrr[u] = 1'b1; xacc[u] = 3'b000;
      for (int r = 0; r < 3; r++) begin
        xa[u][r] = 16'h0000; xb[u][r] = 16'h0000; xexp[u][r] = 16'h0000;
      end
    end

    // Reset state
    step();
    check_val("rst_rsp_valid", 32'(rsp_v), 32'd0);
    check_val("rst_req_ready", 32'(rrdy), 32'd0);
    check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_val("rst_rsp_result", 32'(rsp_res), 32'd0);
    check_val("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;

    // Single shot from requester 2
    rv = 4'b0100;
    #1;
    check_val("ss_ready_idle", 32'(rrdy), 32'd0);
    step();
    check_val("ss_ready_run", 32'(rrdy), 32'h4);
    step();
    rv = 4'b0000;
    check_val("ss_not_yet", 32'(rsp_v), 32'd0);
    step();
    check_val("ss_valid", 32'(rsp_v), 32'd1);
    check_val("ss_id", 32'(rsp_id), 32'd2);
    check_val("ss_result", 32'(rsp_res), 32'h0000C200);
    check_val("ss_sign", 32'(rsp_res[15]), 32'd1);
    step();
    check_val("ss_done", 32'(rsp_v), 32'd0);
    check_val("ss_hold_id", 32'(rsp_id), 32'd2);
    check_val("ss_hold_res", 32'(rsp_res), 32'h0000C200);
    step();
    step();
    check_val("ss_idle", 32'(idle), 32'd1);

    // Round robin with all requesters valid
    do_reset();
    rv = 4'hF; rsp_r = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        rv = 4'h0;
        #1;
      end
      if (i < 8) check_val("rr_grant", 32'(rrdy), 32'(4'b0001 << (i % 4)));
      if (i == 1) check_val("rr_no_rsp", 32'(rsp_v), 32'd0);
      if (i >= 2) begin
        check_val("rr_rsp_valid", 32'(rsp_v), 32'd1);
        check_val("rr_rsp_id", 32'(rsp_id), 32'((i - 2) % 4));
        check_val("rr_rsp_res", 32'(rsp_res), 32'(ep[(i - 2) % 4]));
      end
      step();
    end
    check_val("rr_empty", 32'(rsp_v), 32'd0);

    // Backpressure with full pipeline
    do_reset();
    rv = 4'hF; rsp_r = 1'b1;
    step(); step(); step();
    rsp_r = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_ready", 32'(rrdy), 32'd0);
      check_val("bp_valid", 32'(rsp_v), 32'd1);
      check_val("bp_id", 32'(rsp_id), 32'd0);
      check_val("bp_res", 32'(rsp_res), 32'(ep[0]));
      step();
    end
`ifdef FLOAT_MUL_SCHED_STATS_EN
    check_val("bp_stall_cnt", s0s, 32'd5);
`endif
    rsp_r = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      check_val("bp_rel_valid", 32'(rsp_v), 32'd1);
      check_val("bp_rel_id", 32'(rsp_id), 32'(j % 4));
      check_val("bp_rel_res", 32'(rsp_res), 32'(ep[j % 4]));
      step();
    end
    rv = 4'h0;
    step(); step(); step();

    // Drain with two in flight and others pending
    do_reset();
    rv = 4'hF; rsp_r = 1'b1;
    step(); step(); step();
    drain = 1'b1;
    #1;
    check_val("dr_ready0", 32'(rrdy), 32'd0);
    check_val("dr_rsp0_id", 32'(rsp_id), 32'd0);
    check_val("dr_rsp0_v", 32'(rsp_v), 32'd1);
    step();
    check_val("dr_ready1", 32'(rrdy), 32'd0);
    check_val("dr_rsp1_v", 32'(rsp_v), 32'd1);
    check_val("dr_rsp1_id", 32'(rsp_id), 32'd1);
    check_val("dr_idle1", 32'(idle), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("dr_hold_rsp", 32'(rsp_v), 32'd0);
      check_val("dr_hold_ready", 32'(rrdy), 32'd0);
      check_val("dr_hold_idle", 32'(idle), 32'd0);
    end
    drain = 1'b0; rv = 4'h0;
    step();
    check_val("dr_idle_end", 32'(idle), 32'd1);

    // Reset mid-stream: pointer left at 2 by the drain test
    rv = 4'b0110;
    step();
    check_val("rm_grant_a", 32'(rrdy), 32'h4);
    step();
    check_val("rm_grant_b", 32'(rrdy), 32'h2);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rv = 4'b1010;
    #1;
    check_val("rm_rsp_v", 32'(rsp_v), 32'd0);
    check_val("rm_idle", 32'(idle), 32'd1);
    check_val("rm_rsp_id", 32'(rsp_id), 32'd0);
    step();
    check_val("rm_rsp_v2", 32'(rsp_v), 32'd0);
    check_val("rm_grant_low", 32'(rrdy), 32'h2);
    step();
    rv = 4'h0;
    check_val("rm_rsp_v3", 32'(rsp_v), 32'd0);
    step();
    check_val("rm_new_v", 32'(rsp_v), 32'd1);
    check_val("rm_new_id", 32'(rsp_id), 32'd1);
    check_val("rm_new_res", 32'(rsp_res), 32'(ep[1]));
    step(); step();

    // Random traffic on latency-1 and latency-8 instances
    for (int cyc = 0; cyc < 460; cyc++) begin
      for (int u = 0; u < 2; u++) begin
        for (int r = 0; r < 3; r++) begin
          if (xacc[u][r]) xv[u][r] = 1'b0;
          if (!xv[u][r] && cyc < 400 && $urandom_range(1, 0) == 1) begin
            k = $urandom_range(7, 0);
            xa[u][r] = tab_a[k]; xb[u][r] = tab_b[k]; xexp[u][r] = tab_p[k];
            xv[u][r] = 1'b1;
          end
        end
        xrr[u] = (cyc >= 400) || ($urandom_range(3, 0) != 0);
      end
      #1;
      for (int u = 0; u < 2; u++) begin
        xacc[u] = xv[u] & xrdy[u];
        for (int r = 0; r < 3; r++) begin
          if (xacc[u][r]) sbq[u].push_back({2'(r), xexp[u][r]});
        end
        if (xrv[u] && xrr[u]) begin
          check_val("rnd_expected", 32'(sbq[u].size() != 0), 32'd1);
          if (sbq[u].size() != 0) begin
            ent = sbq[u].pop_front();
            check_val("rnd_id", 32'(xid[u]), 32'(ent[17:16]));
            check_val("rnd_res", 32'(xres[u]), 32'(ent[15:0]));
          end
        end
      end
      step();
    end
    check_val("rnd_left_l1", 32'(sbq[0].size()), 32'd0);
    check_val("rnd_left_l8", 32'(sbq[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/float_mul_scheduler.md
Name: float_mul_scheduler

Overview:
Shares one instance of the team's combinational floating-point multiplier (float_multi) among NUM_REQ requesters. The block does the following:
- Arbitrates round-robin between requesters.
- Registers the operands into a LATENCY-stage valid-tagged pipeline wrapped around the multiplier.
- Returns each product tagged with the requester ID on a single valid/ready response port.
- Provides a drain/flush control so software can quiesce the unit.

Parameters:
- fp_t, fp_pkg::fp16_t: floating-point format of operands and result; passed to float_multi.
- NUM_REQ, 4: number of requesters; legal range 2..16.
- LATENCY, 2: pipeline stages from accept to response; legal range 1..8.
- IDW, $clog2(NUM_REQ): requester ID width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: one clock; reset is synchronous and active-low.
- req_valid_i  in  NUM_REQ  per-requester operand valid.
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_opa_i  in  NUM_REQ x $bits(fp_t)  operand A per requester.
- req_opb_i  in  NUM_REQ x $bits(fp_t)  operand B per requester.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_id_o  out  IDW  originating requester index.
- rsp_result_o  out  $bits(fp_t)  product.
- drain_i  in  1  level; stop accepting new requests while high.
- idle_o  out  1  high when state IDLE and pipeline empty.

Behaviour:
- Reset (rst_ni low at posedge):
  - All pipeline valid bits 0.
  - Round-robin pointer 0.
  - State IDLE.
  - rsp_valid_o=0, req_ready_o=0, rsp_id_o=0, rsp_result_o=0, idle_o=1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions; no response is emitted for them.
- Pipeline:
  - Stage s holds {valid, id, opa, opb} for s=0..LATENCY-1.
  - float_multi sits combinationally between the last stage's operands and rsp_result_o.
  - The last stage is the response register.
- stall = rsp_valid_o & ~rsp_ready_i.
  - On stall, all stages hold. Bubbles do not compress: global stall.
  - When not stalled, all stages advance every cycle.
- Accept condition: state RUN, drain_i low, no stall, and at least one req_valid_i.
  - Grant goes to the first requester with valid set, searching from the rr pointer upward with wrap-around.
  - req_ready_o has exactly the granted bit set. req_ready_o is combinational from req_valid_i, the pointer, the state and stall.
  - The request is accepted in the cycle req_valid_i[g] & req_ready_o[g]. Operands and g are captured into stage 0.
  - The rr pointer becomes (g+1) mod NUM_REQ on accept only.
- Latency: a request accepted at edge t gives rsp_valid_o high after edge t+LATENCY-1 (LATENCY cycles), absent stalls.
  - Throughput is 1 per cycle.
  - Responses leave in acceptance order.
- Response outputs are stable while rsp_valid_o=1 and rsp_ready_i=0.
  - rsp_id_o and rsp_result_o hold their last value when not valid.
- Result arithmetic: rsp_result_o equals float_multi(opa,opb) of the captured operands, bit-exact.
- FSM:
  - IDLE: leave for RUN when any req_valid_i and drain_i low.
  - RUN: go to DRAIN when drain_i rises. Go to IDLE when no req_valid_i and pipeline empty.
  - DRAIN: no accepts. Go to IDLE when pipeline empty and drain_i low. Stay in DRAIN while drain_i is high, even when empty.
- idle_o = (state==IDLE) & no stage valid.
  - The IDLE-to-RUN transition costs one cycle: the first accept happens the cycle after the request appears while IDLE.
- Simultaneous drain_i rise and request: drain wins; no grant that cycle.
- Simultaneous response handshake and new accept: both occur, with no bubble.
- A requester must hold req_valid_i and operands until accepted. The block does not check this.

Optional Feature:
Macro FLOAT_MUL_SCHED_STATS_EN.
- With the macro defined, the block adds these outputs:
  - stat_issue_cnt_o (32 bits): accepted requests.
  - stat_stall_cnt_o (32 bits): cycles with stall=1.
- Both counters reset to 0 and saturate at all-ones.
- Without the macro, these ports and counters do not exist. Other behaviour is identical.

Test Plan:
- Single shot, LATENCY=2: requester 2 presents opa=16'h3E00, opb=16'hC000 while IDLE.
  - Accept occurs the next cycle.
  - rsp_valid_o is high 2 cycles later with rsp_id_o=2, rsp_result_o=float_multi(3E00,C000), and bit 15 (sign) equal to 1.
- All 4 requesters valid continuously, rsp_ready_i=1:
  - Grants are 0,1,2,3,0,1,... one per cycle.
  - Responses carry ids in that order, with no gaps.
- Backpressure: rsp_ready_i=0 for 5 cycles with the pipeline full.
  - req_ready_o is 0 and the outputs are stable throughout.
  - After release, there is no loss or duplication, and order is preserved.
  - With stats enabled, stat_stall_cnt_o=5.
- Drain: raise drain_i with 2 requests in flight and others pending.
  - No further grants.
  - Both responses delivered.
  - idle_o stays 0 until drain_i drops and the pipeline is empty, then goes to 1.
- Reset mid-stream: pulse rst_ni low with 2 requests in flight.
  - rsp_valid_o stays 0 afterwards and the rr pointer is 0.
  - The next grant goes to the lowest valid index.
- Random regression, NUM_REQ=3, LATENCY=1 and LATENCY=8:
  - Random valids and ready.
  - Scoreboard per requester shows every accepted op returns exactly once and bit-exact.
